// File: rtl/inst_fetch.sv
// inst_fetch: 6502 instruction fetch unit feeding prime_decoder.
// After reset it reads the start PC from the reset vector. It then fetches
// the opcode and operand bytes of each instruction over a byte-wide memory
// handshake and holds the complete instruction in a one-entry buffer until
// the decoder takes it. A PC redirect from execute flushes any fetch in flight.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   o_mem_rd/o_mem_addr : read request and address, held until i_mem_ready
//   i_mem_rdata         : read data, valid when o_mem_rd && i_mem_ready
//   i_mem_ready         : completes the read in the same cycle
//   i_pc_load(_val)     : redirect request and target PC
//   o_inst_valid        : buffered instruction available
//   i_inst_ready        : decoder accepts the instruction
//   o_inst_opcode/op1/op2/len/pc : buffered instruction fields
//
// state   | meaning
// --------+----------------------------------------------
// RST     | first cycle after reset, no memory access
// VEC_LO  | reading reset-vector low byte
// VEC_HI  | reading reset-vector high byte
// OPC     | reading opcode at pc
// OP1     | reading first operand byte
// OP2     | reading second operand byte
// HOLD    | instruction offered to decoder, memory idle
module inst_fetch #(
  parameter logic [15:0] VEC_ADDR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_mem_rd,
  output logic [15:0] o_mem_addr,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_load_val,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [7:0]  o_inst_opcode,
  output logic [7:0]  o_inst_op1,
  output logic [7:0]  o_inst_op2,
  output logic [1:0]  o_inst_len,
  output logic [15:0] o_inst_pc
);

  typedef enum logic [2:0] {
    S_RST, S_VEC_LO, S_VEC_HI, S_OPC, S_OP1, S_OP2, S_HOLD
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_mem_rd;
  logic [15:0] r_mem_addr;
  logic        r_valid;
  logic [7:0]  r_opcode;
  logic [7:0]  r_op1;
  logic [7:0]  r_op2;
  logic [1:0]  r_len;
  logic [15:0] r_inst_pc;

  logic [1:0]  w_len;
  logic [15:0] w_pc_inc;

  // Length from the opcode alone; the earlier tests are exceptions to the
  // regular aaabbbcc addressing-mode pattern and must win.
  function automatic logic [1:0] f_len(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    bbb = op[4:2];
    cc  = op[1:0];
    if (op == 8'h00 || op == 8'h40 || op == 8'h60)  f_len = 2'd1;
    else if (op == 8'h20)                            f_len = 2'd3;
    else if (op[4:0] == 5'b10000)                    f_len = 2'd2;
    else if (op[3:0] == 4'b1000)                     f_len = 2'd1;
    else if (op[7] && op[3:0] == 4'b1010)            f_len = 2'd1;
    else if (cc == 2'b11)                            f_len = 2'd1;
    else if (cc == 2'b01)
      f_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
    else begin
      case (bbb)
        3'b000, 3'b001, 3'b101: f_len = 2'd2;
        3'b011, 3'b111:         f_len = 2'd3;
        default:                f_len = 2'd1;
      endcase
    end
  endfunction

  assign w_len    = f_len(i_mem_rdata);
  assign w_pc_inc = r_pc + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RST;
      r_pc       <= 16'h0000;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= VEC_ADDR;
      r_valid    <= 1'b0;
      r_opcode   <= 8'h00;
      r_op1      <= 8'h00;
      r_op2      <= 8'h00;
      r_len      <= 2'd1;
      r_inst_pc  <= 16'h0000;
    end else begin
      case (r_state)
        S_RST: begin
          r_state    <= S_VEC_LO;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= VEC_ADDR;
        end
        S_VEC_LO: begin
          if (i_mem_ready) begin
            r_pc[7:0]  <= i_mem_rdata;
            r_state    <= S_VEC_HI;
            r_mem_addr <= VEC_ADDR + 16'd1;
          end
        end
        S_VEC_HI: begin
          if (i_mem_ready) begin
            r_pc[15:8] <= i_mem_rdata;
            r_state    <= S_OPC;
            r_mem_addr <= {i_mem_rdata, r_pc[7:0]};
          end
        end
        default: begin
          if (i_pc_load) begin
            // Redirect wins over any byte completing now. A held instruction
            // accepted this same cycle has already been taken by the decoder.
            r_pc       <= i_pc_load_val;
            r_state    <= S_OPC;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= i_pc_load_val;
            r_valid    <= 1'b0;
          end else begin
            case (r_state)
              S_OPC: begin
                if (i_mem_ready) begin
                  r_opcode   <= i_mem_rdata;
                  r_inst_pc  <= r_pc;
                  r_len      <= w_len;
                  r_op1      <= 8'h00;
                  r_op2      <= 8'h00;
                  r_pc       <= w_pc_inc;
                  r_mem_addr <= w_pc_inc;
                  if (w_len > 2'd1) begin
                    r_state <= S_OP1;
                  end else begin
                    r_state  <= S_HOLD;
                    r_mem_rd <= 1'b0;
                    r_valid  <= 1'b1;
                  end
                end
              end
              S_OP1: begin
                if (i_mem_ready) begin
                  r_op1      <= i_mem_rdata;
                  r_pc       <= w_pc_inc;
                  r_mem_addr <= w_pc_inc;
                  if (r_len == 2'd3) begin
                    r_state <= S_OP2;
                  end else begin
                    r_state  <= S_HOLD;
                    r_mem_rd <= 1'b0;
                    r_valid  <= 1'b1;
                  end
                end
              end
              S_OP2: begin
                if (i_mem_ready) begin
                  r_op2      <= i_mem_rdata;
                  r_pc       <= w_pc_inc;
                  r_mem_addr <= w_pc_inc;
                  r_state    <= S_HOLD;
                  r_mem_rd   <= 1'b0;
                  r_valid    <= 1'b1;
                end
              end
              S_HOLD: begin
                if (i_inst_ready) begin
                  r_state    <= S_OPC;
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= r_pc;
                  r_valid    <= 1'b0;
                end
              end
              default: r_state <= S_RST;
            endcase
          end
        end
      endcase
    end
  end

  assign o_mem_rd      = r_mem_rd;
  assign o_mem_addr    = r_mem_addr;
  assign o_inst_valid  = r_valid;
  assign o_inst_opcode = r_opcode;
  assign o_inst_op1    = r_op1;
  assign o_inst_op2    = r_op2;
  assign o_inst_len    = r_len;
  assign o_inst_pc     = r_inst_pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  typedef struct {
    logic [7:0]  opc;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
    logic [15:0] pc;
  } inst_t;

  typedef struct {
    logic [7:0] opc;
    logic [1:0] len;
  } lvec_t;

  logic        clk;
  logic        rst_n;
  logic        o_mem_rd;
  logic [15:0] o_mem_addr;
  logic [7:0]  i_mem_rdata;
  logic        i_mem_ready;
  logic        i_pc_load;
  logic [15:0] i_pc_load_val;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [7:0]  o_inst_opcode;
  logic [7:0]  o_inst_op1;
  logic [7:0]  o_inst_op2;
  logic [1:0]  o_inst_len;
  logic [15:0] o_inst_pc;

  logic [7:0] mem [0:65535];
  int wcnt = 0;
  int wait_n = 0;
  int checks = 0;
  int errors = 0;
  inst_t sb[$];
  inst_t vecs[$];
  inst_t mon_e;

  inst_fetch #(.VEC_ADDR(16'hFFFC)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .i_pc_load(i_pc_load), .i_pc_load_val(i_pc_load_val),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst_opcode(o_inst_opcode), .o_inst_op1(o_inst_op1),
    .o_inst_op2(o_inst_op2), .o_inst_len(o_inst_len), .o_inst_pc(o_inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, wait_n wait cycles per request.
  assign i_mem_rdata = mem[o_mem_addr];
  assign i_mem_ready = (wcnt >= wait_n);
  always @(posedge clk) begin
    if (o_mem_rd && !i_mem_ready) wcnt <= wcnt + 1;
    else                          wcnt <= 0;
  end

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    casez (op)
      8'h00, 8'h40, 8'h60:                  return 2'd1;
      8'h20:                                return 2'd3;
      8'b???10000:                          return 2'd2;
      8'b????1000:                          return 2'd1;
      8'b1???1010:                          return 2'd1;
      8'b??????11:                          return 2'd1;
      8'b???01101, 8'b???11001, 8'b???11101: return 2'd3;
      8'b??????01:                          return 2'd2;
      8'b???000?0, 8'b???001?0, 8'b???101?0: return 2'd2;
      8'b???011?0, 8'b???111?0:             return 2'd3;
      default:                              return 2'd1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted instruction must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && o_inst_valid && i_inst_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst actual opc=%h pc=%h expected none", o_inst_opcode, o_inst_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_opcode", {24'd0, o_inst_opcode}, {24'd0, mon_e.opc});
        chk("sb_op1",    {24'd0, o_inst_op1},    {24'd0, mon_e.op1});
        chk("sb_op2",    {24'd0, o_inst_op2},    {24'd0, mon_e.op2});
        chk("sb_len",    {30'd0, o_inst_len},    {30'd0, mon_e.len});
        chk("sb_pc",     {16'd0, o_inst_pc},     {16'd0, mon_e.pc});
      end
    end
  end

  task automatic wait_empty(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
    end
  endtask

  task automatic redirect(input logic [15:0] addr);
    @(posedge clk); #1;
    i_pc_load = 1'b1;
    i_pc_load_val = addr;
    @(posedge clk); #1;
    i_pc_load = 1'b0;
  endtask

  task automatic push(input logic [7:0] opc, input logic [7:0] op1,
                      input logic [7:0] op2, input logic [1:0] len, input logic [15:0] pc);
    inst_t e;
    e.opc = opc; e.op1 = op1; e.op2 = op2; e.len = len; e.pc = pc;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lvec_t hand [12];
    inst_t v;
    logic [15:0] a;

    hand = '{'{8'hA9, 2'd2}, '{8'hAD, 2'd3}, '{8'h0A, 2'd1}, '{8'h20, 2'd3},
             '{8'h6C, 2'd3}, '{8'hD0, 2'd2}, '{8'h60, 2'd1}, '{8'h00, 2'd1},
             '{8'h40, 2'd1}, '{8'hEA, 2'd1}, '{8'h8D, 2'd3}, '{8'h9A, 2'd1}};

    rst_n = 1'b0;
    i_pc_load = 1'b0;
    i_pc_load_val = 16'h0000;
    i_inst_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hEA;

    // Vector table: hand-picked lengths first, then every opcode by the reference rules.
    for (int i = 0; i < 12; i++) begin
      v.opc = hand[i].opc; v.len = hand[i].len;
      v.op1 = 8'h30 + 8'(i); v.op2 = 8'hC0 + 8'(i); v.pc = 16'h0;
      vecs.push_back(v);
    end
    for (int i = 0; i < 256; i++) begin
      v.opc = 8'(i); v.len = ref_len(8'(i));
      v.op1 = 8'(i) ^ 8'h5A; v.op2 = ~8'(i); v.pc = 16'h0;
      vecs.push_back(v);
    end

    push(8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000);
    a = 16'h8001;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      v.pc = a;
      mem[a] = v.opc;
      if (v.len >= 2'd2) mem[a + 16'd1] = v.op1; else v.op1 = 8'h00;
      if (v.len == 2'd3) mem[a + 16'd2] = v.op2; else v.op2 = 8'h00;
      a = a + 16'(v.len);
      sb.push_back(v);
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", {31'd0, o_mem_rd}, 32'd0);
    chk("rst_mem_addr", {16'd0, o_mem_addr}, 32'hFFFC);
    chk("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_opcode", {24'd0, o_inst_opcode}, 32'd0);
    chk("rst_len", {30'd0, o_inst_len}, 32'd1);
    chk("rst_inst_pc", {16'd0, o_inst_pc}, 32'd0);

    // Reset vector sequence
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cycle_mem_rd", {31'd0, o_mem_rd}, 32'd0);
    @(negedge clk);
    chk("vec_lo_rd", {31'd0, o_mem_rd}, 32'd1);
    chk("vec_lo_addr", {16'd0, o_mem_addr}, 32'hFFFC);
    @(negedge clk);
    chk("vec_hi_addr", {16'd0, o_mem_addr}, 32'hFFFD);
    @(negedge clk);
    chk("first_opc_rd", {31'd0, o_mem_rd}, 32'd1);
    chk("first_opc_addr", {16'd0, o_mem_addr}, 32'h8000);

    // Length sweep drains through the scoreboard
    wait_empty(3000);
    @(posedge clk); #1;
    i_inst_ready = 1'b0;

    // Wait states: 8D 34 12, two wait cycles per byte
    mem[16'h9000] = 8'h8D; mem[16'h9001] = 8'h34; mem[16'h9002] = 8'h12;
    push(8'h8D, 8'h34, 8'h12, 2'd3, 16'h9000);
    wait_n = 2;
    redirect(16'h9000);
    // k=0 is the first opcode request cycle; HOLD is the tenth cycle (k=9).
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) chk("ws_opc_addr", {16'd0, o_mem_addr}, 32'h9000);
      if (k == 8) chk("ws_valid_early", {31'd0, o_inst_valid}, 32'd0);
      if (k == 9) chk("ws_valid", {31'd0, o_inst_valid}, 32'd1);
    end

    // Backpressure: held 5 cycles with the decoder stalled
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_mem_rd", {31'd0, o_mem_rd}, 32'd0);
      chk("bp_valid", {31'd0, o_inst_valid}, 32'd1);
      chk("bp_opcode", {24'd0, o_inst_opcode}, 32'h8D);
      chk("bp_op1", {24'd0, o_inst_op1}, 32'h34);
      chk("bp_op2", {24'd0, o_inst_op2}, 32'h12);
      chk("bp_len", {30'd0, o_inst_len}, 32'd3);
      chk("bp_pc", {16'd0, o_inst_pc}, 32'h9000);
    end
    @(posedge clk); #1;
    i_inst_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    i_inst_ready = 1'b0;
    wait_n = 0;
    @(negedge clk);
    chk("bp_next_rd", {31'd0, o_mem_rd}, 32'd1);
    chk("bp_next_addr", {16'd0, o_mem_addr}, 32'h9003);

    // Redirect during OP1 of AD at 8000: AD must never be offered
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h11; mem[16'h8002] = 8'h22;
    mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'h05;
    push(8'hA2, 8'h05, 8'h00, 2'd2, 16'hC000);
    redirect(16'h8000);
    i_inst_ready = 1'b1;
    @(negedge clk);
    chk("rd_opc_addr", {16'd0, o_mem_addr}, 32'h8000);
    @(posedge clk); #1;
    i_pc_load = 1'b1;
    i_pc_load_val = 16'hC000;
    @(negedge clk);
    chk("rd_op1_addr", {16'd0, o_mem_addr}, 32'h8001);
    @(posedge clk); #1;
    i_pc_load = 1'b0;
    @(negedge clk);
    chk("rd_new_addr", {16'd0, o_mem_addr}, 32'hC000);
    chk("rd_new_valid", {31'd0, o_inst_valid}, 32'd0);
    wait_empty(50);
    @(posedge clk); #1;
    i_inst_ready = 1'b0;

    // Wrap at FFFF, then redirect coinciding with acceptance
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
    mem[16'hD000] = 8'h4C; mem[16'hD001] = 8'h00; mem[16'hD002] = 8'hE0;
    push(8'hA9, 8'h77, 8'h00, 2'd2, 16'hFFFF);
    push(8'h4C, 8'h00, 8'hE0, 2'd3, 16'hD000);
    redirect(16'hFFFF);
    i_inst_ready = 1'b1;
    @(negedge clk);
    chk("wrap_opc_addr", {16'd0, o_mem_addr}, 32'hFFFF);
    @(negedge clk);
    chk("wrap_op1_addr", {16'd0, o_mem_addr}, 32'h0000);
    @(posedge clk); #1;
    i_pc_load = 1'b1;
    i_pc_load_val = 16'hD000;
    @(negedge clk);
    chk("sim_valid", {31'd0, o_inst_valid}, 32'd1);
    @(posedge clk); #1;
    i_pc_load = 1'b0;
    @(negedge clk);
    chk("sim_next_addr", {16'd0, o_mem_addr}, 32'hD000);
    chk("sim_next_valid", {31'd0, o_inst_valid}, 32'd0);
    wait_empty(50);
    @(posedge clk); #1;
    i_inst_ready = 1'b0;

    // Asynchronous reset in the middle of a stalled fetch
    wait_n = 3;
    redirect(16'h9000);
    @(negedge clk);
    chk("ar_pre_rd", {31'd0, o_mem_rd}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem_rd", {31'd0, o_mem_rd}, 32'd0);
    chk("ar_mem_addr", {16'd0, o_mem_addr}, 32'hFFFC);
    chk("ar_opcode", {24'd0, o_inst_opcode}, 32'd0);
    chk("ar_inst_pc", {16'd0, o_inst_pc}, 32'd0);
    chk("ar_len", {30'd0, o_inst_len}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the 6502 core, sitting directly upstream of `prime_decoder`. After reset it loads the start PC from the reset vector. It then fetches the opcode and operand bytes of each instruction over a byte-wide memory handshake, working out the instruction length from the opcode alone. Each complete instruction (opcode, up to two operands, length, opcode address) is held in a one-entry buffer and offered to the decoder through a valid/ready handshake. The execute stage can redirect the PC at any time, which flushes any fetch in progress.

## Interface
- `VEC_ADDR`, default `16'hFFFC`: address of the reset-vector low byte; the high byte is at `VEC_ADDR+1`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_rd` in/out: out 1; read request, held high until `mem_ready`.
- `mem_addr` out 16: read address.
- `mem_rdata` in 8: read data, valid in any cycle where `mem_rd && mem_ready`.
- `mem_ready` in 1: completes the read in the same cycle.
- `pc_load` in 1: redirect request (branch, jump, interrupt).
- `pc_load_val` in 16: new PC.
- `inst_valid` out 1: buffered instruction available.
- `inst_ready` in 1: decoder accepts the instruction.
- `inst_opcode` out 8: opcode byte.
- `inst_op1` out 8: first operand byte, or 0.
- `inst_op2` out 8: second operand byte, or 0.
- `inst_len` out 2: instruction length, 1..3.
- `inst_pc` out 16: address of the opcode.

## Operation
- Opcode fields: `aaabbbcc`. Length rules, first match wins:
  - `00`, `40`, `60` → 1; `20` → 3.
  - `xxx10000` → 2; `xxxx1000` → 1; `1xxx1010` → 1.
  - `cc=11` → 1.
  - `cc=01`: bbb ∈ {011,110,111} → 3, otherwise 2.
  - `cc=00`/`10`: bbb 000/001/101 → 2; bbb 011/111 → 3; bbb 010/100/110 → 1.
- FSM states: RST, VEC_LO, VEC_HI, OPC, OP1, OP2, HOLD.
  - RST → VEC_LO unconditionally on the first clock after reset release.
  - VEC_LO: `mem_addr=VEC_ADDR`. On a completed read, capture PC[7:0] and go to VEC_HI.
  - VEC_HI: `mem_addr=VEC_ADDR+1`. On a completed read, capture PC[15:8] and go to OPC.
  - OPC: `mem_addr=pc`. On a completed read, capture `inst_opcode`, set `inst_pc=pc`, compute `inst_len`, clear op1/op2, increment pc. Next state is OP1 if len>1, otherwise HOLD.
  - OP1: on a completed read, capture op1 and increment pc. Next state is OP2 if len=3, otherwise HOLD.
  - OP2: on a completed read, capture op2, increment pc, go to HOLD.
  - HOLD: `inst_valid=1`, `mem_rd=0`. Go to OPC when `inst_ready`.
- `mem_rd` is 1 in VEC_LO, VEC_HI, OPC, OP1 and OP2, and 0 in RST and HOLD. `mem_addr` is stable while `mem_rd && !mem_ready`.
- PC is 16-bit and wraps from `FFFF` to `0000`. Operand fetch across the wrap is legal.
- Redirect: `pc_load` in any state except RST, VEC_LO or VEC_HI sets pc to `pc_load_val` and the state to OPC on the next edge. Any byte completing in that cycle is discarded. A held instruction is dropped unless `inst_ready` is high in the same cycle, in which case the handshake completes and then the redirect applies.
- `pc_load` is ignored in RST, VEC_LO and VEC_HI.

## Timing
- Reset values: state RST, `mem_rd=0`, `mem_addr=VEC_ADDR`, `inst_valid=0`, `inst_opcode`/`op1`/`op2` = 0, `inst_len=1`, `inst_pc=0`, pc=0.
- Reset assertion mid-fetch aborts immediately. All state returns to the reset values asynchronously.
- With `mem_ready` held at 1, an n-byte instruction takes n fetch cycles plus one HOLD cycle. `inst_valid` rises on the edge after the last byte is captured.
- Throughput is one instruction per n+1 cycles when `inst_ready` is held at 1.
- The first `mem_rd` occurs 1 cycle after reset release. The first opcode read occurs 3 cycles after release when there are no wait states.
- Each wait cycle (`mem_ready=0`) extends the current state by one cycle. No other effect.
- All `inst_*` outputs are stable while `inst_valid && !inst_ready`.

## Test plan
- Reset vector: memory `FFFC=00`, `FFFD=80`, `8000=EA`, `ready=1`.
  - Expect `mem_addr` sequence FFFC, FFFD, 8000.
  - Expect `inst_valid` with opcode EA, len 1, `inst_pc=8000`.
- Length decode: sweep all 256 opcodes from a fixed PC.
  - `inst_len` must match the rule list, e.g. A9→2, AD→3, 0A→1, 20→3, 6C→3, D0→2, 60→1.
- Wait states: `8D 34 12` fetched with `mem_ready` low for 2 cycles on each byte.
  - Expect op1=34, op2=12, len 3, `inst_valid` 10 cycles after the first opcode request.
- Backpressure: hold `inst_ready=0` for 5 cycles.
  - Outputs stable and `mem_rd=0` throughout.
  - The next opcode request appears the cycle after ready rises.
- Redirect mid-fetch: `pc_load=1`, `pc_load_val=C000` during OP1 of AD at 8000.
  - No `inst_valid` for AD.
  - Next `mem_addr=C000`.
- Wrap and simultaneous events:
  - Opcode `A9` at FFFF: op1 read from 0000.
  - `pc_load` with `inst_valid && inst_ready` in the same cycle: the instruction is accepted once and the next fetch comes from `pc_load_val`.
